// File: rtl/jtopl_eg_pkg.sv
// rtl/jtopl_eg_pkg.sv - phase encodings, sizing defaults and step patterns for the OPL envelope controller
package jtopl_eg_pkg;

  localparam int EG_SLOTS = 18;
  localparam int EG_CNTW  = 15;

  localparam logic [1:0] PH_ATTACK  = 2'd0;
  localparam logic [1:0] PH_DECAY   = 2'd1;
  localparam logic [1:0] PH_SUSTAIN = 2'd2;
  localparam logic [1:0] PH_RELEASE = 2'd3;

  // Sustain level 15 maps to the very bottom of the attenuation range.
  localparam logic [4:0] SL_MAX_EXT = 5'd31;

  // Indexed by rate6[1:0]; bit position chosen by the counter-derived index.
  localparam logic [3:0][7:0] STEP_PAT = {8'b11111110, 8'b11101110, 8'b11101010, 8'b10101010};

  typedef struct packed {
    logic [1:0] phase;
    logic       keyon_last;
  } eg_slot_t;

  function automatic logic [4:0] sl_ext(input logic [3:0] sl);
    return (sl == 4'd15) ? SL_MAX_EXT : {1'b0, sl};
  endfunction

endpackage

// File: rtl/jtopl_eg_ctrl_if.sv
// rtl/jtopl_eg_ctrl_if.sv - per-slot input and control-output bundle of the envelope controller
interface jtopl_eg_ctrl_if;
  logic       cen;
  logic       zero;
  logic       keyon;
  logic [3:0] arate;
  logic [3:0] drate;
  logic [3:0] rrate;
  logic [3:0] sl;
  logic       en_sus;
  logic       ksr;
  logic [3:0] keycode;
  logic [9:0] eg_in;
  logic       attack;
  logic       step;
  logic [4:0] rate;
  logic       sum_up;
  logic [1:0] state;

  modport master (
    output cen, zero, keyon, arate, drate, rrate, sl, en_sus, ksr, keycode, eg_in,
    input  attack, step, rate, sum_up, state
  );

  modport slave (
    input  cen, zero, keyon, arate, drate, rrate, sl, en_sus, ksr, keycode, eg_in,
    output attack, step, rate, sum_up, state
  );
endinterface

// File: rtl/jtopl_eg_step.sv
// rtl/jtopl_eg_step.sv - maps an effective rate and the global EG counter to step/sum_up
module jtopl_eg_step
  import jtopl_eg_pkg::*;
#(
  parameter int CNTW = EG_CNTW
) (
  input  logic [5:0]      rate6,
  input  logic [CNTW-1:0] eg_cnt,
  output logic            step,
  output logic            sum_up
);

  logic [3:0]      r;
  logic [3:0]      sh;
  logic [CNTW-1:0] mask;
  logic [2:0]      idx;
  logic [7:0]      pat;

  always_comb begin
    r    = rate6[5:2];
    // Slow rates only tick when the low sh counter bits are all zero; fast rates tick every sample.
    sh   = (r < 4'd12) ? (4'd11 - r) : 4'd0;
    mask = (CNTW'(1) << sh) - CNTW'(1);
    idx  = 3'(eg_cnt >> sh);
    pat  = STEP_PAT[rate6[1:0]];
    if (r == 4'd0) begin
      sum_up = 1'b0;
      step   = 1'b0;
    end else begin
      sum_up = ((eg_cnt & mask) == '0);
      step   = pat[idx];
    end
  end

endmodule

// File: rtl/jtopl_eg_ctrl.sv
// rtl/jtopl_eg_ctrl.sv - per-slot ADSR phase tracking, global EG counter and rate/step generation
module jtopl_eg_ctrl
  import jtopl_eg_pkg::*;
#(
  parameter int SLOTS = EG_SLOTS,
  parameter int CNTW  = EG_CNTW
) (
  input  logic           rst_n,
  input  logic           clk,
  jtopl_eg_ctrl_if.slave eg
);

  eg_slot_t        mem [SLOTS];
  eg_slot_t        head;
  logic [CNTW-1:0] eg_cnt;
  logic [1:0]      nxt;
  logic [3:0]      base;
  logic [6:0]      rate_sum;
  logic [5:0]      rate6;
  logic            step_c;
  logic            sum_up_c;

  assign head = mem[0];

  // Key edges override envelope-driven transitions.
  always_comb begin
    nxt = head.phase;
    if (eg.keyon && !head.keyon_last)
      nxt = PH_ATTACK;
    else if (!eg.keyon && head.keyon_last)
      nxt = PH_RELEASE;
    else if (head.phase == PH_ATTACK && eg.eg_in == 10'd0)
      nxt = PH_DECAY;
    else if (head.phase == PH_DECAY && eg.eg_in[9:5] >= sl_ext(eg.sl))
      nxt = PH_SUSTAIN;
  end

  always_comb begin
    case (nxt)
      PH_ATTACK:  base = eg.arate;
      PH_DECAY:   base = eg.drate;
      PH_SUSTAIN: base = eg.en_sus ? 4'd0 : eg.rrate;
      default:    base = eg.rrate;
    endcase
    rate_sum = {1'b0, base, 2'b00}
             + {3'b000, (eg.ksr ? eg.keycode : {2'b00, eg.keycode[3:2]})};
    if (base == 4'd0)
      rate6 = 6'd0;
    else if (rate_sum > 7'd63)
      rate6 = 6'd63;
    else
      rate6 = rate_sum[5:0];
  end

  jtopl_eg_step #(.CNTW(CNTW)) u_step (
    .rate6  (rate6),
    .eg_cnt (eg_cnt),
    .step   (step_c),
    .sum_up (sum_up_c)
  );

  // The head slot is consumed and its updated entry re-enters at the tail, SLOTS cens later it is head again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOTS; i++)
        mem[i] <= '{phase: PH_RELEASE, keyon_last: 1'b0};
      eg_cnt    <= '0;
      eg.attack <= 1'b0;
      eg.step   <= 1'b0;
      eg.rate   <= 5'd0;
      eg.sum_up <= 1'b0;
      eg.state  <= PH_RELEASE;
    end else if (eg.cen) begin
      for (int i = 0; i < SLOTS - 1; i++)
        mem[i] <= mem[i+1];
      mem[SLOTS-1] <= '{phase: nxt, keyon_last: eg.keyon};
      if (eg.zero)
        eg_cnt <= eg_cnt + CNTW'(1);
      eg.attack <= (nxt == PH_ATTACK);
      eg.step   <= step_c;
      eg.rate   <= rate6[5:1];
      eg.sum_up <= sum_up_c;
      eg.state  <= nxt;
    end
  end

endmodule

// File: tb/tb_jtopl_eg_ctrl.sv
// tb/tb_jtopl_eg_ctrl.sv - directed bench for jtopl_eg_ctrl with a per-slot reference model
module tb_jtopl_eg_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jtopl_eg_ctrl_if bif ();

  jtopl_eg_ctrl dut (
    .rst_n (rst_n),
    .clk   (clk),
    .eg    (bif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: array of per-slot phases indexed by slot number, integer counter.
  int m_ph [18];
  int m_kl [18];
  int m_cnt = 0;
  int m_slot = 0;
  int e_attack = 0, e_step = 0, e_rate = 0, e_sum = 0, e_state = 3;
  int pat [4] = '{32'hAA, 32'hEA, 32'hEE, 32'hFE};
  int p, base, r6, r, sh, slx, kin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 18; i++) begin
        m_ph[i] = 3;
        m_kl[i] = 0;
      end
      m_cnt = 0; m_slot = 0;
      e_attack = 0; e_step = 0; e_rate = 0; e_sum = 0; e_state = 3;
    end else if (bif.cen) begin
      kin = bif.keyon ? 1 : 0;
      p   = m_ph[m_slot];
      slx = (int'(bif.sl) == 15) ? 31 : int'(bif.sl);
      if (kin == 1 && m_kl[m_slot] == 0) p = 0;
      else if (kin == 0 && m_kl[m_slot] == 1) p = 3;
      else if (p == 0 && int'(bif.eg_in) == 0) p = 1;
      else if (p == 1 && int'(bif.eg_in) / 32 >= slx) p = 2;
      if (p == 0) base = int'(bif.arate);
      else if (p == 1) base = int'(bif.drate);
      else if (p == 2 && bif.en_sus) base = 0;
      else base = int'(bif.rrate);
      if (base == 0) r6 = 0;
      else begin
        r6 = base * 4 + (bif.ksr ? int'(bif.keycode) : int'(bif.keycode) / 4);
        if (r6 > 63) r6 = 63;
      end
      r = r6 / 4;
      if (r == 0) begin
        e_sum = 0; e_step = 0;
      end else begin
        sh = (r < 12) ? 11 - r : 0;
        e_sum  = ((m_cnt % (1 << sh)) == 0) ? 1 : 0;
        e_step = (pat[r6 % 4] >> ((m_cnt >> sh) % 8)) & 1;
      end
      e_attack = (p == 0) ? 1 : 0;
      e_rate   = r6 / 2;
      e_state  = p;
      m_ph[m_slot] = p;
      m_kl[m_slot] = kin;
      m_slot = (m_slot + 1) % 18;
      if (bif.zero) m_cnt = (m_cnt + 1) % 32768;
    end
  end

  always @(negedge clk) begin
    chk("model",
        int'({bif.attack, bif.step, bif.rate, bif.sum_up, bif.state}),
        (e_attack << 9) | (e_step << 8) | (e_rate << 3) | (e_sum << 2) | e_state);
  end

  int slot = 0;

  task automatic set_idle();
    bif.keyon = 1'b0; bif.arate = 4'd0; bif.drate = 4'd0; bif.rrate = 4'd1;
    bif.sl = 4'd0; bif.en_sus = 1'b1; bif.ksr = 1'b0; bif.keycode = 4'd0;
    bif.eg_in = 10'h3FF;
  endtask

  task automatic tick(input bit zall);
    bif.cen  = 1'b1;
    bif.zero = zall || (slot == 0);
    @(posedge clk);
    #1;
    slot = (slot + 1) % 18;
  endtask

  task automatic idle_until(input int target);
    while (slot != target) begin
      set_idle();
      tick(1'b0);
    end
    set_idle();
  endtask

  int sum_cnt;
  int guard;

  initial begin
    set_idle();
    bif.cen = 1'b1; bif.zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(bif.state), 3);
    chk("rst_attack", int'(bif.attack), 0);
    chk("rst_rate", int'(bif.rate), 0);
    rst_n = 1'b1;
    slot = 0;

    // first frame: every slot in RELEASE at rrate=1 exposes eg_cnt=0
    for (int s = 0; s < 18; s++) begin
      set_idle();
      tick(1'b0);
      chk("frame0_state", int'(bif.state), 3);
      chk("frame0_attack", int'(bif.attack), 0);
      if (s == 0) chk("cnt0_sum", int'(bif.sum_up), 1);
      if (s == 1) chk("cnt1_sum", int'(bif.sum_up), 0);
    end

    idle_until(5);
    bif.keyon = 1'b1; bif.arate = 4'd15;
    tick(1'b0);
    chk("kon_attack", int'(bif.attack), 1);
    chk("kon_rate", int'(bif.rate), 'h1E);
    chk("kon_sum", int'(bif.sum_up), 1);

    bif.cen = 1'b0; bif.keyon = 1'b0; bif.eg_in = 10'd0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("cen_hold_attack", int'(bif.attack), 1);
      chk("cen_hold_rate", int'(bif.rate), 'h1E);
    end

    idle_until(5);
    bif.keyon = 1'b1; bif.eg_in = 10'd0; bif.drate = 4'd6;
    tick(1'b0);
    chk("decay_state", int'(bif.state), 1);
    chk("decay_rate", int'(bif.rate), 'h0C);

    idle_until(5);
    bif.keyon = 1'b1; bif.sl = 4'd4; bif.eg_in = 10'h080; bif.drate = 4'd6;
    tick(1'b0);
    chk("sus_state", int'(bif.state), 2);
    chk("sus_rate", int'(bif.rate), 0);
    chk("sus_sum", int'(bif.sum_up), 0);

    idle_until(5);
    bif.rrate = 4'd8;
    tick(1'b0);
    chk("rel_state", int'(bif.state), 3);
    chk("rel_rate", int'(bif.rate), 'h10);

    sum_cnt = 0;
    for (int f = 0; f < 16; f++) begin
      idle_until(5);
      bif.rrate = 4'd8;
      tick(1'b0);
      sum_cnt += int'(bif.sum_up);
    end
    chk("rel_sum_every8", sum_cnt, 2);

    idle_until(5);
    bif.keyon = 1'b1; bif.arate = 4'd15;
    tick(1'b0);
    chk("rekon_state", int'(bif.state), 0);

    idle_until(5);
    bif.keyon = 1'b1; bif.arate = 4'd15; bif.ksr = 1'b1; bif.keycode = 4'd15;
    tick(1'b0);
    chk("att_hold_state", int'(bif.state), 0);
    chk("ksr_sat_rate", int'(bif.rate), 'h1F);

    idle_until(5);
    bif.keyon = 1'b1; bif.eg_in = 10'd0; bif.drate = 4'd2;
    tick(1'b0);
    chk("decay2_state", int'(bif.state), 1);

    idle_until(5);
    bif.keyon = 1'b1; bif.sl = 4'd15; bif.eg_in = 10'h3C0; bif.en_sus = 1'b0;
    bif.rrate = 4'd3; bif.drate = 4'd2; bif.keycode = 4'd8;
    tick(1'b0);
    chk("sl15_below_state", int'(bif.state), 1);
    chk("sl15_below_rate", int'(bif.rate), 5);

    idle_until(5);
    bif.keyon = 1'b1; bif.sl = 4'd15; bif.eg_in = 10'h3E0; bif.en_sus = 1'b0;
    bif.rrate = 4'd3; bif.drate = 4'd2; bif.keycode = 4'd8;
    tick(1'b0);
    chk("sl15_sus_state", int'(bif.state), 2);
    chk("sus_rr_rate", int'(bif.rate), 7);

    idle_until(5);
    tick(1'b0);
    chk("koff_state", int'(bif.state), 3);
    idle_until(5);
    bif.keyon = 1'b1; bif.arate = 4'd4;
    tick(1'b0);
    chk("kon2_state", int'(bif.state), 0);
    idle_until(5);
    tick(1'b0);
    chk("koff2_state", int'(bif.state), 3);

    // counter wrap: advance eg_cnt on every cen
    guard = 0;
    while (m_cnt != 32'h7FFF && guard < 40000) begin
      set_idle();
      tick(1'b1);
      guard++;
    end
    chk("wrap_reached", m_cnt, 'h7FFF);
    set_idle();
    tick(1'b1);
    chk("wrap_hi_sum", int'(bif.sum_up), 0);
    chk("wrap_hi_step", int'(bif.step), 1);
    set_idle();
    tick(1'b1);
    chk("wrap_lo_sum", int'(bif.sum_up), 1);
    chk("wrap_lo_step", int'(bif.step), 0);
    repeat (2) begin
      set_idle();
      bif.rrate = 4'd11;
      tick(1'b0);
      chk("r11_sum", int'(bif.sum_up), 1);
    end

    // every slot keyed on, then asynchronous reset mid-frame
    repeat (21) begin
      set_idle();
      bif.keyon = 1'b1; bif.arate = 4'd15;
      tick(1'b0);
    end
    chk("pre_rst_attack", int'(bif.attack), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", int'(bif.state), 3);
    chk("midrst_attack", int'(bif.attack), 0);
    chk("midrst_rate", int'(bif.rate), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    slot = 0;
    set_idle();
    bif.keyon = 1'b1; bif.arate = 4'd15;
    tick(1'b0);
    chk("post_rst_state", int'(bif.state), 0);
    chk("post_rst_attack", int'(bif.attack), 1);
    repeat (4) begin
      set_idle();
      tick(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    errors++;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
